// File: rtl/jk_seq_pkg.sv
// Shared types and helpers for the JK sequence driver: FSM states and the
// JK excitation function that turns a (present, desired) bit pair into J/K.
package jk_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHold
  } state_e;

  typedef struct packed {
    logic j;
    logic k;
  } jk_t;

  localparam jk_t JkNoChange = '{j: 1'b0, k: 1'b0};

  // Don't-cares resolve to 0, so the toggle pair J=K=1 is never produced.
  function automatic jk_t exc(input logic q, input logic t);
    jk_t r;
    r.j = ~q & t;
    r.k = q & ~t;
    return r;
  endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// One JK flip-flop bit with synchronous active-low reset.
module jk_ff_cell (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q, q_d;

  assign q_d = (j & ~q_q) | (~k & q_q);
  assign q   = q_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/jk_sequence_driver.sv
// Steps a bank of JK cells through a loaded table of states by deriving J/K
// from the present state and the next table entry.
module jk_sequence_driver
  import jk_seq_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [WIDTH-1:0] load_data,
  input  logic [AW:0]      seq_len,
  input  logic             start,
  input  logic             hold,
  input  logic             stop,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             wrap
);

  localparam logic [AW:0] DepthLen = (AW + 1)'(DEPTH);
  localparam logic [AW:0] LenOne   = (AW + 1)'(1);

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [AW:0]      len_q, len_d;
  logic             wrap_q, wrap_d;
  logic             step;
  logic             last;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] tbl_q [DEPTH];

  assign target = tbl_q[idx_q];
  assign last   = ({1'b0, idx_q} == (len_q - LenOne));
  assign busy   = (state_q != StIdle);
  assign wrap   = wrap_q;

  // Table is deliberately not reset; writes only land while idle.
  always_ff @(posedge clk) begin
    if (reset && (state_q == StIdle) && load_en) begin
      tbl_q[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    wrap_d  = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && (seq_len != '0)) begin
          state_d = StRun;
          idx_d   = '0;
          len_d   = (seq_len > DepthLen) ? DepthLen : seq_len;
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StIdle;
          idx_d   = '0;
        end else if (hold) begin
          state_d = StHold;
        end else begin
          step   = 1'b1;
          wrap_d = last;
          idx_d  = last ? '0 : idx_q + 1'b1;
        end
      end
      StHold: begin
        if (stop) begin
          state_d = StIdle;
          idx_d   = '0;
        end else if (!hold) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      len_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      wrap_q  <= wrap_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_t e;

    // Any non-stepping cycle (idle, hold, stop, reset) drives the no-change pair.
    assign e    = (step && reset) ? exc(Q[i], target[i]) : JkNoChange;
    assign J[i] = e.j;
    assign K[i] = e.k;

    jk_ff_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (J[i]),
      .k     (K[i]),
      .q     (Q[i])
    );
  end

endmodule

// File: tb/tb_jk_sequence_driver.sv
// Scoreboard bench for jk_sequence_driver: a step-count reference model pushes
// expected J/K and post-edge state; a monitor pops and compares each cycle.
module tb_jk_sequence_driver;

  localparam int W  = 4;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [W-1:0]  load_data;
  logic [AW:0]   seq_len;
  logic          start;
  logic          hold;
  logic          stop;
  logic [W-1:0]  J;
  logic [W-1:0]  K;
  logic [W-1:0]  Q;
  logic          busy;
  logic          wrap;

  always #5 clk = ~clk;

  jk_sequence_driver #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .seq_len   (seq_len),
    .start     (start),
    .hold      (hold),
    .stop      (stop),
    .J         (J),
    .K         (K),
    .Q         (Q),
    .busy      (busy),
    .wrap      (wrap)
  );

  typedef struct {
    logic [W-1:0] q;
    logic         busy;
    logic         wrap;
  } st_exp_t;

  typedef struct {
    logic [W-1:0] j;
    logic [W-1:0] k;
  } jk_exp_t;

  st_exp_t st_q[$];
  jk_exp_t jk_q[$];

  int errors = 0;
  int checks = 0;

  // Reference model: a running flag, a step counter k and the sequence length;
  // after each step Q is table[k mod len].
  logic [W-1:0] m_tbl [D];
  logic [W-1:0] m_q    = '0;
  bit           m_run  = 1'b0;
  bit           m_hold = 1'b0;
  bit           m_wrap = 1'b0;
  int           m_k    = 0;
  int           m_len  = 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rst_n, input bit le, input int la, input int ld, input int sl,
                       input bit st, input bit ho, input bit sp);
    jk_exp_t      je;
    st_exp_t      se;
    logic [W-1:0] t;
    reset     = rst_n;
    load_en   = le;
    load_addr = la[AW-1:0];
    load_data = ld[W-1:0];
    seq_len   = sl[AW:0];
    start     = st;
    hold      = ho;
    stop      = sp;

    je.j = '0;
    je.k = '0;
    if (rst_n && m_run && !m_hold && !sp && !ho) begin
      t = m_tbl[m_k % m_len];
      for (int b = 0; b < W; b++) begin
        if (m_q[b] != t[b]) begin
          if (t[b]) je.j[b] = 1'b1;
          else      je.k[b] = 1'b1;
        end
      end
    end
    jk_q.push_back(je);

    m_wrap = 1'b0;
    if (!rst_n) begin
      m_q    = '0;
      m_run  = 1'b0;
      m_hold = 1'b0;
    end else if (!m_run) begin
      if (le) m_tbl[la % D] = ld[W-1:0];
      if (st && sl != 0) begin
        m_run  = 1'b1;
        m_hold = 1'b0;
        m_k    = 0;
        m_len  = (sl > D) ? D : sl;
      end
    end else if (sp) begin
      m_run  = 1'b0;
      m_hold = 1'b0;
    end else if (m_hold) begin
      m_hold = ho;
    end else if (ho) begin
      m_hold = 1'b1;
    end else begin
      m_q    = m_tbl[m_k % m_len];
      m_wrap = ((m_k % m_len) == m_len - 1);
      m_k++;
    end

    se.q    = m_q;
    se.busy = m_run;
    se.wrap = m_wrap;
    st_q.push_back(se);

    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load(input int a, input int d);
    drive(1, 1, a, d, 0, 0, 0, 0);
  endtask

  task automatic run_to_q3();
    for (int i = 0; i < 8 && !(m_run && m_q == 4'd3); i++) idle(1);
  endtask

  initial begin
    jk_exp_t je;
    st_exp_t se;
    forever begin
      @(negedge clk);
      if (jk_q.size() > 0) begin
        je = jk_q.pop_front();
        check("J", J, je.j);
        check("K", K, je.k);
        check("J_and_K", J & K, '0);
      end
      @(posedge clk);
      #1;
      if (st_q.size() > 0) begin
        se = st_q.pop_front();
        check("Q", Q, se.q);
        check("busy", W'(busy), W'(se.busy));
        check("wrap", W'(wrap), W'(se.wrap));
      end
    end
  end

  initial begin
    reset     = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    seq_len   = '0;
    start     = 1'b0;
    hold      = 1'b0;
    stop      = 1'b0;
    @(posedge clk);
    #2;

    // Reset held with start asserted.
    drive(0, 0, 0, 0, 4, 1, 0, 0);
    drive(0, 0, 0, 0, 4, 1, 0, 0);

    // Gray sequence 0,1,3,2.
    load(0, 0);
    load(1, 1);
    load(2, 3);
    load(3, 2);
    drive(1, 0, 0, 0, 4, 1, 0, 0);
    idle(9);

    // Hold at Q=3 for three cycles, resume, then stop.
    run_to_q3();
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 1, 0);
    idle(3);
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    idle(2);

    // seq_len = 0 is ignored.
    drive(1, 0, 0, 0, 0, 1, 0, 0);
    idle(2);

    // Full random table, seq_len clamps to DEPTH; loads while running are ignored.
    for (int a = 0; a < D; a++) load(a, int'($urandom_range(0, 15)));
    drive(1, 0, 0, 0, 12, 1, 0, 0);
    for (int i = 0; i < 20; i++)
      drive(1, 1, int'($urandom_range(0, D - 1)), int'($urandom_range(0, 15)), 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 8, 1, 0, 0);
    idle(10);
    drive(1, 0, 0, 0, 0, 0, 0, 1);

    // seq_len = 1 with table[0]=F: Q stays F, wrap every cycle.
    load(0, 15);
    drive(1, 0, 0, 0, 1, 1, 0, 0);
    idle(6);
    drive(1, 0, 0, 0, 0, 0, 0, 1);

    // Mid-run reset at Q=3, then restart from table[0].
    load(0, 0);
    load(1, 1);
    load(2, 3);
    load(3, 2);
    drive(1, 0, 0, 0, 4, 1, 0, 0);
    run_to_q3();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    drive(1, 0, 0, 0, 4, 1, 0, 0);
    idle(6);
    drive(1, 0, 0, 0, 0, 0, 0, 1);

    // Random mix; load and start in the same cycle are exercised here too.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 64) != 0, ($urandom % 4) == 0, int'($urandom_range(0, D - 1)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), ($urandom % 4) == 0,
            ($urandom % 8) == 0, ($urandom % 16) == 0);
    end
    idle(2);

    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (st_q.size() != 0 || jk_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d state and %0d jk expectations left, required 0",
               st_q.size(), jk_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jk_sequence_driver.md
# jk_sequence_driver

Programmable state-sequence generator built on a bank of JK flip-flops. It is the inverse of a JK flip-flop: instead of computing a next state from J/K, it derives J/K from the present state Q and a desired next state using the JK excitation table. Each bit cell then updates Q, so Q steps through a user-loaded table of states. It sits beside the lab JK flip-flop blocks as a stimulus source and a sequence/counter engine.

## Interface
- WIDTH, 4: bits per state word (number of JK cells).
- DEPTH, 8: table entries; power of two, ≥2.
- AW, derived = clog2(DEPTH).
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset, sampled on rising clk.
- load_en  in  1  write table entry (accepted only in IDLE).
- load_addr  in  AW  table index to write.
- load_data  in  WIDTH  state word to write.
- seq_len  in  AW+1  sequence length, sampled at start.
- start  in  1  begin sequencing (IDLE only).
- hold  in  1  freeze Q and index while running.
- stop  in  1  return to IDLE; Q retained.
- J  out  WIDTH  per-bit J excitation, combinational.
- K  out  WIDTH  per-bit K excitation, combinational.
- Q  out  WIDTH  flip-flop bank state.
- busy  out  1  high in RUN or HOLD.
- wrap  out  1  one-cycle pulse when the index wraps from the last entry to 0.

## Operation
- Reset (reset=0 at an edge): Q=0, idx=0, len_r=0, state=IDLE, wrap=0. Table contents are not reset; they read as X until written. J=K=0 in the same cycle that the reset is sampled.
- Excitation per bit, from (Q, target): 0→0: J=0,K=0. 0→1: J=1,K=0. 1→0: J=0,K=1. 1→1: J=0,K=0. Don't-cares resolve to 0, so J=K=1 (toggle) is never produced.
- Cell update: Q ← (J & ~Q) | (~K & Q).
- target = table[idx] in RUN. In IDLE or HOLD, J=K=0.
- FSM:
  - IDLE: load_en writes table[load_addr] ← load_data. start with seq_len≠0 latches len_r = min(seq_len, DEPTH), sets idx=0, and moves to RUN. start with seq_len=0 is ignored.
  - RUN: each edge, Q takes target and idx advances. When idx = len_r−1, idx returns to 0 and wrap is asserted on the next cycle. hold=1 moves to HOLD with no update on that edge.
  - HOLD: Q and idx frozen. hold=0 returns to RUN.
  - stop from RUN or HOLD moves to IDLE with no Q update; idx is cleared.
- Priority: reset > stop > hold > step.
- load_en outside IDLE is ignored. start outside IDLE is ignored.

## Timing
- start sampled at edge n gives RUN from cycle n. Q = table[0] after edge n+1, and Q = table[k mod len_r] after edge n+1+k, ignoring hold cycles.
- J/K are valid combinationally throughout each RUN cycle and describe the transition taken at the next edge.
- wrap is a registered output. It is high for the one cycle following the edge at which Q took table[len_r−1].
- len_r=1: Q holds table[0] and wrap pulses every cycle.
- reset deasserted mid-RUN is not special; reset asserted mid-RUN aborts to IDLE with Q=0 on that edge.
- load_en and start in the same IDLE cycle: the write lands and start is accepted. A write to entry 0 is seen as the first target.

## Structure
- Package jk_seq_pkg holds:
  - state enum {IDLE, RUN, HOLD};
  - the excitation function exc(q, t) → {j, k};
  - the constant for the no-change excitation (J=K=0).
- Sub-module jk_ff_cell holds one JK bit with synchronous active-low reset. The top level instantiates WIDTH of them.
- Top level holds the table register file, idx/len_r counters, FSM and wrap register.

## Test plan
- Reset: drive reset=0 for 2 cycles with start=1 → Q=0, busy=0, J=K=0, wrap=0.
- Gray sequence, WIDTH=4: load 0,1,3,2 at addresses 0–3, seq_len=4, start → Q follows 0,1,3,2,0,1… J on the 0→1 step = 0001. J on the 1→3 step = 0010. K on the 3→2 step = 0001. wrap pulses once per 4 cycles.
- Hold/stop: in RUN at Q=3, hold for 3 cycles → Q=3 and J=K=0 throughout, then resumes at 2. stop → busy=0 and Q retained.
- Boundaries:
  - seq_len=0 → start ignored.
  - seq_len=12 with DEPTH=8 → len_r=8.
  - seq_len=1 with table[0]=F → Q=F and wrap high continuously.
- Guarding: load_en during RUN leaves the table unchanged, checked after stop plus restart. Assert J&K == 0 every cycle.
- Mid-run reset: reset=0 while Q=3 → Q=0 and IDLE on that edge; restart begins again at table[0].
